// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the pipelined MIPS CPU stage registers.
//
// Contents:
//   NOP_INSTR      - bubble instruction (sll $0,$0,0), driven on empty stages
//   stage_state_e  - occupancy state of a stage register, encoded as
//                    {main_valid, skid_valid} so it decodes straight from the
//                    entry valid bits
//   *_t bundles    - payload carried across each stage boundary
//   *_W constants  - payload width for each boundary, derived from the bundles
//   occ_count()    - number of held entries from the two valid bits
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Encoding matches {main_valid, skid_valid}; 2'b01 can never occur because
   // the skid entry is only filled while main is already held.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } stage_state_e;

   // IF/ID: fetched instruction plus the incremented PC for branch targets.
   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] instr;
   } if_id_t;

   // ID/EX: register operands, sign-extended immediate, register numbers and
   // the decoded control bits consumed by EX, MEM and WB.
   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        reg_dst;
      logic        branch;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
   } id_ex_t;

   // EX/MEM: ALU result, store data and the destination register.
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] rt_val;
      logic [4:0]  dest;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
   } ex_mem_t;

   // MEM/WB: both candidate write-back values and the write-back controls.
   typedef struct packed {
      logic [31:0] mem_data;
      logic [31:0] alu_result;
      logic [4:0]  dest;
      logic        mem_to_reg;
      logic        reg_write;
   } mem_wb_t;

   localparam int IF_ID_W  = $bits(if_id_t);
   localparam int ID_EX_W  = $bits(id_ex_t);
   localparam int EX_MEM_W = $bits(ex_mem_t);
   localparam int MEM_WB_W = $bits(mem_wb_t);

   // Held-entry count; both operands are widened so the sum cannot wrap.
   function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_if
// One valid/ready payload link between two pipeline stages.
//
// Signals:
//   valid  - producer presents a payload this cycle
//   ready  - consumer accepts the payload this cycle
//   data   - WIDTH-bit payload
//
// Modports:
//   master - producer side (drives valid/data, observes ready)
//   slave  - consumer side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_reg_if #(
   parameter int WIDTH = 32
);

   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One held payload slot of a pipeline stage register: a WIDTH-bit payload
// register plus its valid bit.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, clears valid
//   load   in   capture d and mark the entry valid (wins over clear)
//   clear  in   mark the entry invalid
//   d      in   payload to capture
//   q      out  held payload (only meaningful while valid=1)
//   valid  out  entry holds a payload
// ---------------------------------------------------------------------------
module pipe_entry #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   // Valid bit: reset and clear empty the slot, a load fills it. Load wins
   // over clear so a simultaneous refill keeps the slot occupied.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

   // Payload register is only written on an enabled load; it carries no
   // reset because its contents are never observed while valid=0.
   always_ff @(posedge clk) begin
      if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline stage register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a bubble value when empty.
//
// Parameters:
//   WIDTH      payload width of this stage boundary
//   NOP_VALUE  payload presented downstream while out valid=0
//   SKID       1 = main + skid entry, registered upstream ready
//              0 = main entry only, combinational upstream ready
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   squash all held entries and any incoming payload
//   up         slave link from the upstream stage (in_valid/in_ready/in_data)
//   dn         master link to the downstream stage (out_valid/out_ready/out_data)
//   occupancy  out  number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter int               SKID      = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   pipe_stage_reg_if.slave         up,
   pipe_stage_reg_if.master        dn,
   output logic [1:0]              occupancy
);

   logic             in_xfer;
   logic             out_xfer;
   logic             main_valid;
   logic             skid_valid;
   logic             main_load;
   logic             main_clear;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] main_q;

   // A transfer happens on each side whenever valid and ready meet.
   assign in_xfer  = up.valid & up.ready;
   assign out_xfer = dn.valid & dn.ready;

   // The main entry is always present and always feeds the downstream link.
   pipe_entry #(
      .WIDTH (WIDTH)
   ) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .q     (main_q),
      .valid (main_valid)
   );

   if (SKID != 0) begin : g_skid

      logic             skid_load;
      logic             skid_clear;
      logic [WIDTH-1:0] skid_q;
      stage_state_e     state;

      // Second slot catches the payload that was already in flight when the
      // downstream stall arrived, so upstream ready can be a plain register.
      pipe_entry #(
         .WIDTH (WIDTH)
      ) u_skid (
         .clk   (clk),
         .rst   (rst),
         .load  (skid_load),
         .clear (skid_clear),
         .d     (up.data),
         .q     (skid_q),
         .valid (skid_valid)
      );

      // The entry valid bits are the state register; decode them here.
      assign state = stage_state_e'({main_valid, skid_valid});

      // Next-state logic expressed as entry load/clear strobes. Flush empties
      // both slots and suppresses every load, which also discards an input
      // transfer in the same cycle. An output transfer in a flush cycle needs
      // no special case: the payload was sampled downstream and is cleared.
      always_comb begin
         main_load  = 1'b0;
         main_clear = 1'b0;
         skid_load  = 1'b0;
         skid_clear = 1'b0;
         main_d     = up.data;
         if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
         end else begin
            case (state)
               ST_EMPTY: begin
                  main_load = in_xfer;
               end
               ST_ONE: begin
                  if (in_xfer && out_xfer) begin
                     main_load = 1'b1;
                  end else if (in_xfer) begin
                     skid_load = 1'b1;
                  end else if (out_xfer) begin
                     main_clear = 1'b1;
                  end
               end
               ST_FULL: begin
                  // Upstream is held off in FULL, so only the drain case exists.
                  if (out_xfer) begin
                     main_load  = 1'b1;
                     main_d     = skid_q;
                     skid_clear = 1'b1;
                  end
               end
               default: begin
                  main_clear = 1'b1;
                  skid_clear = 1'b1;
               end
            endcase
         end
      end

      // Upstream ready depends only on the skid valid register, breaking the
      // combinational ready chain through the pipeline.
      assign up.ready = ~skid_valid;

   end else begin : g_noskid

      assign skid_valid = 1'b0;

      // Single slot: refill on any accepted input, drain only when nothing
      // replaces the departing payload. Flush clears and blocks the refill.
      always_comb begin
         main_d     = up.data;
         main_load  = in_xfer & ~flush;
         main_clear = flush | (out_xfer & ~in_xfer);
      end

      // The slot frees up in the same cycle it drains, so ready looks through
      // to the downstream ready.
      assign up.ready = ~main_valid | dn.ready;

   end

   // Downstream outputs: the bubble value masks the payload register whenever
   // the main slot is empty, so stale or uninitialised data never leaks out.
   always_comb begin
      dn.valid  = main_valid;
      dn.data   = main_valid ? main_q : NOP_VALUE;
      occupancy = occ_count(main_valid, skid_valid);
   end

endmodule
